// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution datapath controllers.
// The state encoding and the output-count helper are used by every controller variant.
package conv_ctrl_pkg;

   typedef enum logic [2:0] {FILL, STREAM, DRAIN, DONE} conv_ctrl_state_t;

   function automatic int calc_n_out(input int x_size, input int f_size);
      return x_size - f_size + 1;
   endfunction

endpackage

// File: rtl/pline_token_tracker.sv
// One valid bit per datapath stage; a token enters stage 0 on each enabled cycle.
// Reports whether the last stage may advance and whether the pipe is (or will be) empty.
module pline_token_tracker #(
   parameter int PLINE_STAGES = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic i_shift_en,
   input  logic i_tok_in,
   input  logic i_m_ready,
   output logic o_can_adv,
   output logic o_m_valid,
   output logic o_empty,
   output logic o_empty_next
);

   logic [PLINE_STAGES-1:0] r_vld_sr;
   logic [PLINE_STAGES-1:0] w_vld_shift;

   generate
      if (PLINE_STAGES == 1) begin : g_single
         assign w_vld_shift = i_tok_in;
      end else begin : g_multi
         assign w_vld_shift = {r_vld_sr[PLINE_STAGES-2:0], i_tok_in};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_sr <= '0;
      end else if (i_shift_en) begin
         r_vld_sr <= w_vld_shift;
      end
   end

   // The last stage may only move when its token is being consumed or it holds a bubble.
   assign o_can_adv    = !r_vld_sr[PLINE_STAGES-1] || i_m_ready;
   assign o_m_valid    = r_vld_sr[PLINE_STAGES-1];
   assign o_empty      = (r_vld_sr == '0);
   assign o_empty_next = i_shift_en ? (w_vld_shift == '0) : (r_vld_sr == '0);

endmodule

// File: rtl/ctrl_xmem_stream.sv
// Streaming controller for the convolution datapath: window fill, token-tracked pipeline, y handshake.
// Define CTRL_PERF_CNT_EN to add the stall_cycles / bubble_cycles performance counters.
module ctrl_xmem_stream
   import conv_ctrl_pkg::*;
#(
   parameter int X_SIZE       = 128,
   parameter int F_SIZE       = 32,
   parameter int PLINE_STAGES = 5,
   localparam int N_OUT       = calc_n_out(X_SIZE, F_SIZE),
   localparam int YW          = $clog2(N_OUT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          conv_start,
   input  logic          m_ready,
   output logic          m_valid,
   output logic          xmem_wr_en,
   output logic          xmem_full,
   output logic          en_pline_stages,
   output logic          tok_in,
   output logic [YW-1:0] y_index,
`ifdef CTRL_PERF_CNT_EN
   output logic [31:0]   stall_cycles,
   output logic [31:0]   bubble_cycles,
`endif
   output logic          conv_done
);

   localparam int CW = $clog2(X_SIZE + 1);
   localparam logic [CW-1:0] C_FILL_LAST = CW'(F_SIZE - 1);
   localparam logic [CW-1:0] C_FILL_PRE  = CW'(F_SIZE - 2);
   localparam logic [CW-1:0] C_X_LAST    = CW'(X_SIZE - 1);
   localparam logic [CW-1:0] C_X_FULL    = CW'(X_SIZE);
   localparam logic [YW-1:0] C_Y_LAST    = YW'(N_OUT - 1);

   conv_ctrl_state_t r_state;
   logic [CW-1:0]    r_in_cnt;
   logic [YW-1:0]    r_y_index;
   logic w_can_adv, w_en, w_wr, w_tok, w_m_valid, w_empty, w_empty_next, w_s_ready, w_y_hs;

   // In STREAM a sample is only taken when its token can enter stage 0 this cycle.
   always_comb begin
      w_s_ready = 1'b0;
      case (r_state)
         FILL:    w_s_ready = (r_in_cnt < C_FILL_LAST);
         STREAM:  w_s_ready = w_can_adv && (r_in_cnt < C_X_FULL);
         default: w_s_ready = 1'b0;
      endcase
      if (reset) w_s_ready = 1'b0;
   end

   assign w_wr   = s_valid && w_s_ready;
   assign w_en   = w_can_adv && (r_state != FILL);
   assign w_tok  = w_wr && (r_in_cnt >= C_FILL_LAST) && (r_state == STREAM);
   assign w_y_hs = w_m_valid && m_ready;

   pline_token_tracker #(.PLINE_STAGES(PLINE_STAGES)) u_tracker (
      .clk          (clk),
      .reset        (reset),
      .i_shift_en   (w_en),
      .i_tok_in     (w_tok),
      .i_m_ready    (m_ready),
      .o_can_adv    (w_can_adv),
      .o_m_valid    (w_m_valid),
      .o_empty      (w_empty),
      .o_empty_next (w_empty_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= FILL;
         r_in_cnt  <= '0;
         r_y_index <= '0;
      end else begin
         if (w_wr && (r_in_cnt != C_X_FULL)) r_in_cnt <= r_in_cnt + 1'b1;
         if (w_y_hs) r_y_index <= (r_y_index == C_Y_LAST) ? '0 : r_y_index + 1'b1;
         case (r_state)
            // The write that completes the window may coincide with conv_start already being high.
            FILL: if (conv_start && ((r_in_cnt == C_FILL_LAST) || (w_wr && (r_in_cnt == C_FILL_PRE))))
                     r_state <= STREAM;
            STREAM: if (w_wr && (r_in_cnt == C_X_LAST)) r_state <= DRAIN;
            DRAIN:  if (w_empty || w_empty_next) r_state <= DONE;
            DONE: begin
               r_state   <= FILL;
               r_in_cnt  <= '0;
               r_y_index <= '0;
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign s_ready         = w_s_ready;
   assign xmem_wr_en      = w_wr;
   assign en_pline_stages = w_en;
   assign tok_in          = w_tok;
   assign m_valid         = w_m_valid;
   assign y_index         = r_y_index;
   assign conv_done       = (r_state == DONE);
   assign xmem_full       = ((r_state == FILL) && (r_in_cnt == C_FILL_LAST)) ||
                            (r_state == STREAM) || (r_state == DRAIN);

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] r_stall_cycles, r_bubble_cycles;

   always_ff @(posedge clk) begin
      if (reset || (r_state == DONE)) begin
         r_stall_cycles  <= '0;
         r_bubble_cycles <= '0;
      end else begin
         if (w_m_valid && !m_ready && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 1'b1;
         if ((r_state == STREAM) && w_en && !w_tok && (r_bubble_cycles != '1))
            r_bubble_cycles <= r_bubble_cycles + 1'b1;
      end
   end

   assign stall_cycles  = r_stall_cycles;
   assign bubble_cycles = r_bubble_cycles;
`endif

endmodule

// File: doc/ctrl_xmem_stream.md
Name: ctrl_xmem_stream

Overview:
- Parametrised successor controller for the convolution datapath.
- Shifts X samples into the F_SIZE-deep sliding window memory and drives the datapath pipeline enables.
- Produces the output valid/ready handshake and signals end of convolution.
- Replaces fixed flush counting with a per-stage valid-token shift register, so the pipeline may carry bubbles, input and output overlap freely, and every stage is credit-safe under output backpressure.

Parameters:
- X_SIZE, 128, number of x samples per convolution
- F_SIZE, 32, filter length / window depth; 2 <= F_SIZE <= X_SIZE
- PLINE_STAGES, 5, datapath pipeline depth (>=1)
- N_OUT, X_SIZE-F_SIZE+1, derived localparam: outputs per convolution (not overridable)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid&&s_ready
- conv_start  in  1  filter memory loaded; level, sampled in FILL only
- m_ready  in  1  downstream accepts y
- m_valid  out  1  y valid at pipeline output
- xmem_wr_en  out  1  shift-in strobe to window memory (= s_valid&&s_ready)
- xmem_full  out  1  window holds F_SIZE samples, convolution in progress
- en_pline_stages  out  1  advance all datapath stages this cycle
- tok_in  out  1  valid token entering stage 0 this cycle (drives datapath accumulate-clear)
- y_index  out  $clog2(N_OUT+1)  index of the y currently offered on m_valid (0..N_OUT-1)
- conv_done  out  1  one-cycle pulse after the last y is accepted

Behaviour:
- Reset: state=FILL; in_cnt=0; vld_sr=0; y_index=0; all outputs 0.
  - Reset mid-operation discards all tokens.
  - No m_valid in the cycle after reset.
- Counters:
  - in_cnt, width $clog2(X_SIZE+1), counts accepted samples and saturates at X_SIZE.
  - vld_sr[PLINE_STAGES-1:0] holds one valid bit per stage.
- adv = !vld_sr[PLINE_STAGES-1] || m_ready; en_pline_stages = adv && (state != FILL).
- m_valid = vld_sr[PLINE_STAGES-1]; registered, no combinational path from m_ready.
- tok_in = xmem_wr_en && in_cnt >= F_SIZE-1 && state==STREAM.
  - When en_pline_stages: vld_sr <= {vld_sr[PLINE_STAGES-2:0], tok_in}.
- States:
  - FILL:
    - s_ready=1 while in_cnt < F_SIZE-1.
    - At in_cnt==F_SIZE-1: s_ready=0 and xmem_full=1.
    - Wait there until conv_start==1, then go to STREAM.
    - conv_start already high during filling -> STREAM the cycle after the (F_SIZE-1)th write.
  - STREAM:
    - s_ready = adv && in_cnt < X_SIZE, so a sample is only accepted when its token can enter the pipeline.
    - The write taking in_cnt to X_SIZE -> DRAIN.
  - DRAIN:
    - s_ready=0; pipeline advances on adv with tok_in=0.
    - When vld_sr becomes all-zero -> DONE.
    - This coincides with the final y accepted (m_valid && m_ready on y_index==N_OUT-1).
  - DONE:
    - conv_done=1 for exactly one cycle; xmem_full=0; in_cnt, y_index cleared.
    - Next state FILL; s_ready=0 in DONE.
- y_index increments on m_valid && m_ready and clears in DONE.
- Boundaries:
  - Output stall: m_valid held, en_pline_stages=0, s_ready=0; no sample or token lost.
  - Input bubble: s_valid=0 in STREAM still advances the pipeline with tok_in=0 (bubble).
  - Simultaneous accept and output: both occur the same cycle, giving full throughput of 1 y/cycle.
  - F_SIZE==X_SIZE: exactly one y produced.
  - PLINE_STAGES==1: vld_sr shift degenerates to vld_sr <= tok_in.
- Latency: sample enabling y[k] -> m_valid after PLINE_STAGES cycles, assuming no stalls.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
  - Defined: adds outputs stall_cycles[31:0] (cycles with m_valid && !m_ready) and bubble_cycles[31:0] (cycles in STREAM with en_pline_stages && !tok_in).
  - Both counters clear on reset and on conv_done and saturate at all-ones.
  - Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_ctrl_pkg:
  - typedef enum logic [2:0] {FILL, STREAM, DRAIN, DONE} conv_ctrl_state_t.
  - Function for the N_OUT computation.
- Sub-module pline_token_tracker (PLINE_STAGES): holds vld_sr, inputs adv/tok_in/m_ready, outputs m_valid/empty.
  - Reusable by the future weight-stationary datapath controller.

Test Plan (X_SIZE=8, F_SIZE=3, PLINE_STAGES=2, N_OUT=6):
- conv_start=1 throughout, s_valid=1, m_ready=1 -> 8 writes on consecutive cycles; m_valid first seen 2 cycles after the 3rd write; 6 consecutive y with y_index 0..5; conv_done pulses 1 cycle after the y_index=5 handshake.
- conv_start raised 5 cycles after 2 samples written -> s_ready=0 and xmem_full=1 during the wait; 3rd write occurs only after conv_start; total exactly 6 y.
- m_ready low 4 cycles while m_valid high -> y_index and m_valid held, en_pline_stages=0, s_ready=0, no xmem_wr_en; sequence resumes with no loss or duplication.
- s_valid toggled 1/0 -> bubbles appear; m_valid gaps match; still exactly 6 y, conv_done once.
- Reset asserted mid-STREAM after y_index=2 -> next cycle all outputs 0, state FILL; a full new convolution then completes correctly.
- With CTRL_PERF_CNT_EN, the 4-cycle stall case -> stall_cycles=4 at conv_done, cleared to 0 the following cycle.
